// File: rtl/frame_capture_ctrl.sv
// Single-frame capture sequencer: arms on request, waits for frame start, then
// writes one H_ACTIVE x V_ACTIVE luminance frame to linear frame-buffer addresses.
module frame_capture_ctrl #(
  parameter int HCOUNT_WIDTH = 11,
  parameter int VCOUNT_WIDTH = 10,
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 360,
  parameter int ADDR_WIDTH   = 18
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    capture_req_in,
  input  logic                    abort_in,
  input  logic                    pixel_valid_in,
  input  logic [HCOUNT_WIDTH-1:0] pixel_hcount_in,
  input  logic [VCOUNT_WIDTH-1:0] pixel_vcount_in,
  input  logic [7:0]              pixel_data_in,
  output logic                    bram_we_out,
  output logic [ADDR_WIDTH-1:0]   bram_addr_out,
  output logic [7:0]              bram_data_out,
  output logic                    busy_out,
  output logic                    frame_done_out,
  output logic                    frame_error_out,
  output logic [7:0]              frame_count_out
);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    CAPTURE
  } state_t;

  localparam logic [HCOUNT_WIDTH-1:0] H_LAST = HCOUNT_WIDTH'(H_ACTIVE - 1);
  localparam logic [VCOUNT_WIDTH-1:0] V_LAST = VCOUNT_WIDTH'(V_ACTIVE - 1);

  state_t                  state_q, state_d;
  logic [HCOUNT_WIDTH-1:0] exp_h_q, exp_h_d;
  logic [VCOUNT_WIDTH-1:0] exp_v_q, exp_v_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;

  logic in_window;
  logic pos_match;
  logic last_pos;
  logic write_en;
  logic done_evt;
  logic err_evt;

  assign in_window = (pixel_hcount_in <= H_LAST) && (pixel_vcount_in <= V_LAST);
  assign pos_match = (pixel_hcount_in == exp_h_q) && (pixel_vcount_in == exp_v_q);
  assign last_pos  = (exp_h_q == H_LAST) && (exp_v_q == V_LAST);

  // State, raster tracking and registered outputs.
  // NOTE: every sequential assignment uses <= so all flops update from pre-edge values.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q         <= IDLE;
      exp_h_q         <= '0;
      exp_v_q         <= '0;
      addr_q          <= '0;
      bram_we_out     <= 1'b0;
      bram_addr_out   <= '0;
      bram_data_out   <= '0;
      busy_out        <= 1'b0;
      frame_done_out  <= 1'b0;
      frame_error_out <= 1'b0;
      frame_count_out <= '0;
    end else begin
      state_q         <= state_d;
      exp_h_q         <= exp_h_d;
      exp_v_q         <= exp_v_d;
      addr_q          <= addr_d;
      bram_we_out     <= write_en;
      busy_out        <= (state_d != IDLE);
      frame_done_out  <= done_evt;
      frame_error_out <= err_evt;
      if (write_en) begin
        bram_addr_out <= addr_q;
        bram_data_out <= pixel_data_in;
      end
      if (done_evt) frame_count_out <= frame_count_out + 8'd1;
    end
  end

  // Next state; the raster trackers sit at (0,0)/addr 0 whenever idle, which makes
  // ARMED's frame-start detection the same position match used during CAPTURE.
  always_comb begin
    // NOTE: defaults first so no path through this block can infer a latch.
    state_d = state_q;
    exp_h_d = exp_h_q;
    exp_v_d = exp_v_q;
    addr_d  = addr_q;

    unique case (state_q)
      IDLE:    if (capture_req_in) state_d = ARMED;
      ARMED,
      CAPTURE: begin
        if (err_evt || done_evt) state_d = IDLE;
        else if (write_en)       state_d = CAPTURE;
      end
      default: state_d = IDLE;
    endcase

    if (write_en) begin
      addr_d = addr_q + 1'b1;
      if (exp_h_q == H_LAST) begin
        exp_h_d = '0;
        exp_v_d = exp_v_q + 1'b1;
      end else begin
        exp_h_d = exp_h_q + 1'b1;
      end
    end

    if (state_d == IDLE) begin
      exp_h_d = '0;
      exp_v_d = '0;
      addr_d  = '0;
    end
  end

  // Per-cycle events; abort outranks pixel handling.
  always_comb begin
    write_en = 1'b0;
    done_evt = 1'b0;
    err_evt  = 1'b0;
    unique case (state_q)
      ARMED: begin
        if (abort_in) begin
          err_evt = 1'b1;
        end else if (pixel_valid_in && pos_match) begin
          write_en = 1'b1;
          done_evt = last_pos;
        end
      end
      CAPTURE: begin
        if (abort_in) begin
          err_evt = 1'b1;
        end else if (pixel_valid_in && in_window) begin
          if (pos_match) begin
            write_en = 1'b1;
            done_evt = last_pos;
          end else begin
            err_evt = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: doc/frame_capture_ctrl.md
Name: frame_capture_ctrl

Overview:
- Sequences single-frame captures from the luminance pixel stream into the peripheral FPGA's frame buffer.
- A capture request arms the block, which then:
  - waits for the next frame start (pixel h=0, v=0);
  - writes exactly H_ACTIVE x V_ACTIVE luminance bytes to linear BRAM addresses;
  - reports done or error.
- Sits between the camera luminance reconstructor and the frame BRAM that the SPI transmitter later reads.

Parameters:
- HCOUNT_WIDTH, 11, width of pixel_hcount_in
- VCOUNT_WIDTH, 10, width of pixel_vcount_in
- H_ACTIVE, 640, captured pixels per line (h = 0..H_ACTIVE-1)
- V_ACTIVE, 360, captured lines per frame (v = 0..V_ACTIVE-1)
- ADDR_WIDTH, 18, BRAM address width; must satisfy 2^ADDR_WIDTH >= H_ACTIVE*V_ACTIVE

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous active-high reset
- capture_req_in  input  1  single-cycle request to capture the next full frame
- abort_in  input  1  cancels any pending or in-progress capture
- pixel_valid_in  input  1  one-cycle strobe per pixel
- pixel_hcount_in  input  HCOUNT_WIDTH  pixel column
- pixel_vcount_in  input  VCOUNT_WIDTH  pixel row
- pixel_data_in  input  8  luminance byte
- bram_we_out  output  1  frame buffer write enable
- bram_addr_out  output  ADDR_WIDTH  write address
- bram_data_out  output  8  write data
- busy_out  output  1  high in ARMED or CAPTURE
- frame_done_out  output  1  one-cycle pulse on successful capture
- frame_error_out  output  1  one-cycle pulse on aborted or corrupted capture
- frame_count_out  output  8  completed captures, wraps 255->0

Behaviour:
- Single clock domain; synchronous active-high reset on clk_in/rst_in.
- Reset values:
  - state IDLE;
  - all outputs 0;
  - internal expected_h, expected_v and write address counter all 0.
- States: IDLE, ARMED, CAPTURE.
- IDLE:
  - capture_req_in=1 -> ARMED.
  - Pixels are ignored.
- ARMED:
  - Waits for pixel_valid_in with h=0, v=0.
  - On that pixel:
    - issue its write (addr 0);
    - set expected_h=1, expected_v=0, addr counter=1;
    - go to CAPTURE.
  - All other pixels are ignored.
- CAPTURE, on each pixel_valid_in:
  - Out of window (h >= H_ACTIVE or v >= V_ACTIVE): ignored, no write, no error.
  - In window and (h,v) == (expected_h, expected_v): write at current addr counter, then advance.
    - Advance: expected_h+1; at H_ACTIVE wrap to 0 and increment expected_v.
    - Addr counter +1.
  - In window and mismatch (dropped or repeated pixel, or new frame start at 0,0 before completion):
    - no write;
    - frame_error_out pulse;
    - -> IDLE.
  - The write of (H_ACTIVE-1, V_ACTIVE-1):
    - frame_done_out pulse coincident with that write;
    - frame_count_out+1;
    - -> IDLE.
- Output timing:
  - Write outputs are registered: bram_we/addr/data are valid exactly 1 cycle after the accepted pixel_valid_in cycle.
  - bram_we_out is a 1-cycle pulse.
  - Address = v*H_ACTIVE + h, generated by the counter, not by a multiplier.
- busy_out:
  - Registered; reflects the next state.
  - Rises the cycle after the request, falls with done/error.
- abort_in:
  - In ARMED or CAPTURE: -> IDLE, frame_error_out pulse, no write that cycle.
  - In IDLE: no effect.
  - Has priority over pixel processing.
- capture_req_in while ARMED/CAPTURE: ignored (no queueing).
- Simultaneous capture_req_in and abort_in in IDLE: request wins (-> ARMED).
- Simultaneous abort_in and capture_req_in in ARMED/CAPTURE: abort wins, then IDLE; the request is dropped.
- After done or error, a new capture_req_in is accepted on the following cycle.
- Reset mid-capture:
  - immediate IDLE;
  - no done/error pulse;
  - frame_count_out cleared;
  - pending bram_we_out cleared the next cycle.
- Counter widths: counters must not overflow for maximum parameter values; comparisons are unsigned.

Test Plan:
- Nominal capture with H_ACTIVE=8, V_ACTIVE=4 (bench override):
  - Stimulus: request, then a full 10x6 raster with pixel_data = h+8*v.
  - Required: 32 writes, addr 0..31, data = addr; frame_done_out 1 cycle after the last write's input; frame_count_out=1; busy_out low after.
- Arm mid-frame:
  - Stimulus: request at pixel (3,2), raster continues into the next frame.
  - Required: no writes until the next (0,0); then a full 32-write capture.
- Dropped pixel:
  - Stimulus: skip pixel (5,1) in CAPTURE.
  - Required: writes for addr 0..12 only; frame_error_out pulse on arrival of (6,1); state IDLE; frame_count_out unchanged.
- Abort:
  - Stimulus: abort_in asserted after 10 writes.
  - Required: frame_error_out pulse that cycle; no further writes; new request then completes normally.
- Reset:
  - Stimulus: rst_in for 1 cycle mid-capture.
  - Required: all outputs 0 the next cycle; no done/error; frame_count_out=0.
- Wrap and ignored requests:
  - Stimulus: 256 back-to-back captures, with extra capture_req_in pulses during CAPTURE.
  - Required: extra requests have no effect; frame_count_out wraps to 0 after the 256th done.
